tcp_rx: RTL

TCP_RX -- requirements
Module: tcp_rx

---
 rtl/tcp_rx.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tcp_rx.sv
// TCP segment receiver: parses the header, verifies the checksum against the
// pseudo-header, tracks rcv_nxt/connection state and delivers in-order payload.
module tcp_rx #(
  parameter int          PAYLOAD_LEN = 262,
  parameter logic [7:0]  PROTOCOL    = 8'd6,
  parameter logic [31:0] SRCADDR     = 32'h7f000001,
  parameter logic [31:0] DESADDR     = 32'h7f000001,
  parameter logic [15:0] LOCAL_PORT  = 16'd9000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_last,
  output logic                     rx_ready,
  output logic                     fix_valid,
  output logic [PAYLOAD_LEN*8-1:0] fix_data,
  output logic [8:0]               fix_len,
  output logic                     ack_valid,
  output logic [31:0]              ack_num,
  output logic [15:0]              peer_port,
  output logic [5:0]               rcv_flags,
  output logic [1:0]               conn_state,
  output logic                     drop,
  output logic [2:0]               drop_cause
);

  localparam logic [1:0]  LISTEN  = 2'd0;
  localparam logic [1:0]  ESTAB   = 2'd1;
  localparam logic [1:0]  CLOSED  = 2'd2;
  localparam logic [15:0] MAX_PAY = 16'(PAYLOAD_LEN);

  typedef enum logic [2:0] {IDLE, HDR, OPT, PAY, CHECK, OUT} state_t;
  state_t state_reg, state_next;

  logic [15:0] cnt_reg, cnt_inc, hdr_len, pay_len;
  logic [31:0] acc_reg, seq_reg, rcv_nxt_reg, sum_full;
  logic [15:0] src_reg, dst_reg, fold2;
  logic [16:0] fold1;
  logic [3:0]  doff_reg;
  logic [5:0]  flags_reg;
  logic [1:0]  conn_reg;
  logic [2:0]  cause;
  logic        take, fix_load;
  logic [7:0]  pay_mem [PAYLOAD_LEN];
  wire  [PAYLOAD_LEN*8-1:0] fix_next;

  assign rx_ready   = (state_reg != CHECK) && (state_reg != OUT);
  assign take       = rx_valid && rx_ready;
  assign cnt_inc    = cnt_reg + 16'd1;
  assign hdr_len    = {10'd0, doff_reg, 2'b00};
  // While in PAY this is the payload index of the current byte; in CHECK it is the payload length.
  assign pay_len    = cnt_reg - hdr_len;
  assign ack_num    = rcv_nxt_reg;
  assign conn_state = conn_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, HDR, OPT, PAY: begin
        if (take) begin
          if (rx_last)                state_next = CHECK;
          else if (cnt_inc < 16'd20)  state_next = HDR;
          else if (cnt_inc < hdr_len) state_next = OPT;
          else                        state_next = PAY;
        end
      end
      CHECK:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte counter, running checksum and header field capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      acc_reg   <= '0;
      src_reg   <= '0;
      dst_reg   <= '0;
      seq_reg   <= '0;
      doff_reg  <= '0;
      flags_reg <= '0;
    end else if (state_reg == OUT) begin
      cnt_reg <= '0;
      acc_reg <= '0;
    end else if (take) begin
      cnt_reg <= cnt_inc;
      acc_reg <= acc_reg + (cnt_reg[0] ? {24'd0, rx_data} : {16'd0, rx_data, 8'd0});
      case (cnt_reg)
        16'd0:  src_reg[15:8]   <= rx_data;
        16'd1:  src_reg[7:0]    <= rx_data;
        16'd2:  dst_reg[15:8]   <= rx_data;
        16'd3:  dst_reg[7:0]    <= rx_data;
        16'd4:  seq_reg[31:24]  <= rx_data;
        16'd5:  seq_reg[23:16]  <= rx_data;
        16'd6:  seq_reg[15:8]   <= rx_data;
        16'd7:  seq_reg[7:0]    <= rx_data;
        16'd12: doff_reg        <= rx_data[7:4];
        16'd13: flags_reg       <= rx_data[5:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (take && state_reg == PAY && pay_len < MAX_PAY)
      pay_mem[pay_len[8:0]] <= rx_data;
  end

  assign sum_full = acc_reg + {16'd0, SRCADDR[31:16]} + {16'd0, SRCADDR[15:0]}
                  + {16'd0, DESADDR[31:16]} + {16'd0, DESADDR[15:0]}
                  + {24'd0, PROTOCOL} + {16'd0, cnt_reg};
  assign fold1 = {1'b0, sum_full[15:0]} + {1'b0, sum_full[31:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

  always_comb begin
    cause = 3'd0;
    if (cnt_reg < 16'd20 || cnt_reg < hdr_len)                            cause = 3'd1;
    else if (doff_reg < 4'd5)                                             cause = 3'd2;
    else if (fold2 != 16'hFFFF)                                           cause = 3'd3;
    else if (dst_reg != LOCAL_PORT)                                       cause = 3'd4;
    else if (pay_len > MAX_PAY)                                           cause = 3'd5;
    else if ((pay_len != 16'd0 || !flags_reg[1]) && conn_reg != ESTAB)    cause = 3'd6;
    else if (conn_reg == ESTAB && seq_reg != rcv_nxt_reg)                 cause = 3'd7;
  end

  assign fix_load = (cause == 3'd0) && !flags_reg[2] && !flags_reg[1] && (pay_len != 16'd0);

  // Delivered payload is masked to its length so stale buffer bytes never leak out.
  generate
    for (genvar gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_fix
      assign fix_next[gi*8 +: 8] = (16'(gi) < pay_len) ? pay_mem[gi] : 8'd0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      conn_reg    <= LISTEN;
      rcv_nxt_reg <= '0;
      fix_valid   <= 1'b0;
      fix_data    <= '0;
      fix_len     <= '0;
      ack_valid   <= 1'b0;
      peer_port   <= '0;
      rcv_flags   <= '0;
      drop        <= 1'b0;
      drop_cause  <= '0;
    end else begin
      fix_valid <= 1'b0;
      ack_valid <= 1'b0;
      drop      <= 1'b0;
      if (state_reg == CHECK) begin
        if (cause != 3'd0) begin
          drop       <= 1'b1;
          drop_cause <= cause;
          ack_valid  <= (cause == 3'd7);
        end else begin
          peer_port <= src_reg;
          rcv_flags <= flags_reg;
          if (flags_reg[2]) begin
            conn_reg <= LISTEN;
          end else if (flags_reg[1]) begin
            rcv_nxt_reg <= seq_reg + 32'd1;
            conn_reg    <= ESTAB;
            ack_valid   <= 1'b1;
          end else begin
            rcv_nxt_reg <= rcv_nxt_reg + {16'd0, pay_len} + {31'd0, flags_reg[0]};
            ack_valid   <= (pay_len != 16'd0) || flags_reg[0];
            if (flags_reg[0]) conn_reg <= CLOSED;
            if (fix_load) begin
              fix_valid <= 1'b1;
              fix_len   <= pay_len[8:0];
              fix_data  <= fix_next;
            end
          end
        end
      end
    end
  end

endmodule
